// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for a 16-bit asynchronous SRAM.
// Each 32-bit request is split into low/high halfword SET/ACC phases.
module sram_arbiter (
  input  logic        clk,
  input  logic        nReset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_be,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_be,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        CS,
  output logic        WE,
  output logic        OE,
  output logic        LBS,
  output logic        HBS,
  output logic [19:0] addr,
  inout  wire  [15:0] data
);

  localparam int unsigned WordW = 19;
  localparam int unsigned HalfW = 16;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = 4;
  localparam int unsigned SramW = 20;

  typedef enum logic [2:0] {IDLE, LO_SET, LO_ACC, HI_SET, HI_ACC, DONE} state_t;

  typedef struct packed {
    logic             we;
    logic [WordW-1:0] word;
    logic [DataW-1:0] wdata;
    logic [BeW-1:0]   be;
  } req_t;

  state_t           state, stateNext;
  req_t             cur, curNext;
  logic             owner, ownerNext;
  logic             lastGrant, lastGrantNext;
  logic             grantOne;
  logic             active, hiHalf, accPhase;
  logic             csNext, weNext, oeNext, lbsNext, hbsNext;
  logic [SramW-1:0] addrNext;
  logic             dataOe, dataOeNext;
  logic [HalfW-1:0] dataOut, dataOutNext;
  logic [HalfW-1:0] rdLo;
  logic             unusedAddrBits;

  assign unusedAddrBits = ^{req0_addr[31:21], req0_addr[1:0], req1_addr[31:21], req1_addr[1:0]};
  assign data = dataOe ? dataOut : {HalfW{1'bz}};

  always_ff @(posedge clk) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  end

  // Arbitration, phase sequencing and next values for the registered SRAM pins
  always_comb begin
    stateNext     = state;
    curNext       = cur;
    ownerNext     = owner;
    lastGrantNext = lastGrant;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    grantOne      = (req0_valid && req1_valid) ? !lastGrant : req1_valid;
    case (state)
      IDLE: begin
        if (nReset && (req0_valid || req1_valid)) begin
          req0_ready    = !grantOne;
          req1_ready    = grantOne;
          ownerNext     = grantOne;
          lastGrantNext = grantOne;
          curNext = grantOne ? req_t'({req1_we, req1_addr[20:2], req1_wdata, req1_be})
                             : req_t'({req0_we, req0_addr[20:2], req0_wdata, req0_be});
          if (!curNext.we || curNext.be[1:0] != 2'b00)  stateNext = LO_SET;
          else if (curNext.be[3:2] != 2'b00)           stateNext = HI_SET;
          else                                         stateNext = DONE;
        end
      end
      LO_SET:  stateNext = LO_ACC;
      LO_ACC:  stateNext = (cur.we && cur.be[3:2] == 2'b00) ? DONE : HI_SET;
      HI_SET:  stateNext = HI_ACC;
      HI_ACC:  stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    hiHalf      = (stateNext == HI_SET) || (stateNext == HI_ACC);
    accPhase    = (stateNext == LO_ACC) || (stateNext == HI_ACC);
    active      = hiHalf || (stateNext == LO_SET) || (stateNext == LO_ACC);
    csNext      = !active;
    oeNext      = !(active && !curNext.we);
    weNext      = !(active && curNext.we && accPhase);
    lbsNext     = !active || (curNext.we && !(hiHalf ? curNext.be[2] : curNext.be[0]));
    hbsNext     = !active || (curNext.we && !(hiHalf ? curNext.be[3] : curNext.be[1]));
    addrNext    = active ? {curNext.word, hiHalf} : '0;
    dataOeNext  = active && curNext.we;
    dataOutNext = !dataOeNext ? '0 : (hiHalf ? curNext.wdata[31:16] : curNext.wdata[15:0]);
  end

  // Latched request, registered pins, completion and read capture
  always_ff @(posedge clk) begin
    if (!nReset) begin
      cur        <= '0;
      owner      <= 1'b0;
      lastGrant  <= 1'b1;
      CS         <= 1'b1;
      WE         <= 1'b1;
      OE         <= 1'b1;
      LBS        <= 1'b1;
      HBS        <= 1'b1;
      addr       <= '0;
      dataOe     <= 1'b0;
      dataOut    <= '0;
      rdLo       <= '0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      cur       <= curNext;
      owner     <= ownerNext;
      lastGrant <= lastGrantNext;
      CS        <= csNext;
      WE        <= weNext;
      OE        <= oeNext;
      LBS       <= lbsNext;
      HBS       <= hbsNext;
      addr      <= addrNext;
      dataOe    <= dataOeNext;
      dataOut   <= dataOutNext;
      req0_done <= (stateNext == DONE) && !ownerNext;
      req1_done <= (stateNext == DONE) && ownerNext;
      if (state == LO_ACC && !cur.we) rdLo <= data;
      if (state == HI_ACC && !cur.we) begin
        if (owner) req1_rdata <= {data, rdLo};
        else       req0_rdata <= {data, rdLo};
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on the pins, a phase-list scoreboard
// checked every cycle, and directed requests with literal expectations.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        nReset;
  logic        req0_valid, req0_we, req0_ready, req0_done;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic [3:0]  req0_be;
  logic        req1_valid, req1_we, req1_ready, req1_done;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic [3:0]  req1_be;
  logic        CS, WE, OE, LBS, HBS;
  logic [19:0] addr;
  wire  [15:0] data;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .nReset(nReset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_ready(req0_ready),
    .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_ready(req1_ready),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .CS(CS), .WE(WE), .OE(OE), .LBS(LBS), .HBS(HBS), .addr(addr), .data(data)
  );

  // Undriven bus reads as all ones
  for (genvar gi = 0; gi < 16; gi++) begin : gPull
    pullup pu (data[gi]);
  end

  // Asynchronous SRAM model, small window of the address space
  logic [15:0] sramMem [256] = '{default: 16'h0000};
  logic [7:0]  sIdx;
  assign sIdx = addr[7:0];
  assign data = (!CS && !OE && WE) ? sramMem[sIdx] : 16'bz;
  always @(posedge clk) begin
    if (!CS && !WE) begin
      if (!LBS) sramMem[sIdx][7:0]  <= data[7:0];
      if (!HBS) sramMem[sIdx][15:8] <= data[15:8];
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nVec++;
    if (act !== expv) begin
      nErr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
    end
  endfunction

  // Reference model: one entry per expected cycle after acceptance
  typedef struct {
    logic        isDone;
    logic        cs, we, oe, lbs, hbs;
    logic [19:0] a;
    logic        drive;
    logic [15:0] dv;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] refMem [256] = '{default: 16'h0000};
  logic [31:0] expRdata [2] = '{32'h0, 32'h0};
  int          curPort;
  logic        curWe;
  logic [31:0] curAddr, curWdata, rdExp;
  logic [3:0]  curBe;
  int          lastGrant = 1;
  bit          armed = 0;

  function automatic int hIdx(input logic [31:0] a, input int h);
    return (int'(a[20:2]) * 2 + h) % 256;
  endfunction

  task automatic pushTxn(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    curPort = p; curWe = we; curAddr = a; curWdata = wd; curBe = be;
    rdExp = {refMem[hIdx(a, 1)], refMem[hIdx(a, 0)]};
    for (int h = 0; h < 2; h++) begin
      logic [1:0] hb;
      hb = (h == 0) ? be[1:0] : be[3:2];
      if (!we || hb != 2'b00) begin
        e.isDone = 1'b0;
        e.cs     = 1'b0;
        e.oe     = we;
        e.lbs    = we ? !hb[0] : 1'b0;
        e.hbs    = we ? !hb[1] : 1'b0;
        e.a      = {a[20:2], 1'(h)};
        e.drive  = we;
        e.dv     = (h == 0) ? wd[15:0] : wd[31:16];
        e.we     = 1'b1;
        expQ.push_back(e);
        e.we     = !we;
        expQ.push_back(e);
      end
    end
    e = '{default: '0};
    e.isDone = 1'b1;
    expQ.push_back(e);
  endtask

  // Every-cycle comparison against the model
  initial begin : compare
    exp_t e;
    bit   busy;
    int   g;
    forever begin
      @(negedge clk);
      if (armed) begin
        busy = (expQ.size() != 0);
        if (busy) e = expQ.pop_front();
        else      e = '{default: '0};
        if (busy && !e.isDone) begin
          chk("CS", 32'(CS), 32'(e.cs));
          chk("WE", 32'(WE), 32'(e.we));
          chk("OE", 32'(OE), 32'(e.oe));
          chk("LBS", 32'(LBS), 32'(e.lbs));
          chk("HBS", 32'(HBS), 32'(e.hbs));
          chk("addr", 32'(addr), 32'(e.a));
          if (e.drive) chk("wdata", 32'(data), 32'(e.dv));
        end else begin
          chk("idleCtl", 32'({CS, WE, OE, LBS, HBS}), 32'h1F);
          chk("idleBus", 32'(data), 32'hFFFF);
        end
        if (busy && e.isDone) begin
          if (curWe) begin
            for (int h = 0; h < 2; h++)
              for (int b = 0; b < 2; b++)
                if (curBe[2*h+b]) refMem[hIdx(curAddr, h)][8*b +: 8] = curWdata[16*h+8*b +: 8];
          end else begin
            expRdata[curPort] = rdExp;
          end
        end
        chk("done0", 32'(req0_done), 32'(busy && e.isDone && curPort == 0));
        chk("done1", 32'(req1_done), 32'(busy && e.isDone && curPort == 1));
        chk("rdata0", req0_rdata, expRdata[0]);
        chk("rdata1", req1_rdata, expRdata[1]);
        g = -1;
        if (!busy && nReset) begin
          if (req0_valid && req1_valid) g = 1 - lastGrant;
          else if (req0_valid)          g = 0;
          else if (req1_valid)          g = 1;
        end
        chk("ready0", 32'(req0_ready), 32'(g == 0));
        chk("ready1", 32'(req1_ready), 32'(g == 1));
        if (g == 0) begin
          pushTxn(0, req0_we, req0_addr, req0_wdata, req0_be);
          lastGrant = 0;
        end else if (g == 1) begin
          pushTxn(1, req1_we, req1_addr, req1_wdata, req1_be);
          lastGrant = 1;
        end
      end
      if (!nReset) begin
        armed = 1;
        expQ.delete();
        lastGrant = 1;
        expRdata[0] = '0;
        expRdata[1] = '0;
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd; req0_be = be;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd; req1_be = be;
    end
  endtask

  task automatic junk(input int p);
    drive(p, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
  endtask

  task automatic waitReady(output int g);
    g = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req0_ready) begin g = 0; break; end
      if (req1_ready) begin g = 1; break; end
    end
    if (g < 0) begin
      nVec++; nErr++;
      $display("FAIL readyTimeout: no ready within 20 cycles at %0t", $time);
    end
  endtask

  task automatic waitDone(input int p, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((p == 0 && req0_done) || (p == 1 && req1_done)) begin lat = k; break; end
    end
  endtask

  task automatic doReq(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int expLat, input string nm);
    int g, lat;
    drive(p, 1'b1, we, a, wd, be);
    waitReady(g);
    chk({nm, "_grant"}, 32'(g), 32'(p));
    @(posedge clk); #1;
    junk(p);
    waitDone(p, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(expLat));
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    @(posedge clk); #1 nReset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int order [3];
    int g, lat;
    nReset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    chk("rstCtl", 32'({CS, WE, OE, LBS, HBS}), 32'h1F);
    chk("rstBus", 32'(data), 32'hFFFF);
    chk("rstReady", 32'({req0_ready, req1_ready}), 32'h0);
    chk("rstDone", 32'({req0_done, req1_done}), 32'h0);
    chk("rstRdata0", req0_rdata, 32'h0);
    @(posedge clk); #1;
    nReset = 1'b1;
    junk(0); junk(1);

    doReq(0, 1'b1, 32'h0000_0000, 32'h00AB_CDEF, 4'hF, 5, "wrFull");
    chk("mem0", 32'(sramMem[0]), 32'hCDEF);
    chk("mem1", 32'(sramMem[1]), 32'h00AB);
    doReq(1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 5, "rdFull");
    chk("rdFullVal", req1_rdata, 32'h00AB_CDEF);

    doReq(0, 1'b1, 32'h0000_0004, 32'h1234_5678, 4'b0011, 3, "wrLo");
    doReq(0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 5, "rdLo");
    chk("rdLoVal", req0_rdata, 32'h0000_5678);
    doReq(1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0000, 1, "wrNone");
    doReq(1, 1'b0, 32'hFFE0_0007, 32'h0, 4'h0, 5, "rdAlias");
    chk("rdAliasVal", req1_rdata, 32'h0000_5678);

    doReq(0, 1'b1, 32'h0000_0008, 32'h1122_3344, 4'b0100, 3, "wrHi");
    doReq(0, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 5, "rdHi");
    chk("rdHiVal", req0_rdata, 32'h0022_0000);

    // Simultaneous requests alternate starting from req0 after reset
    doReset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
      drive(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
      waitReady(g);
      order[i] = g;
      @(posedge clk); #1;
      if (g == 0) junk(0); else junk(1);
      if (i == 2) begin junk(0); junk(1); end
      waitDone(g, lat);
      chk("rrLat", 32'(lat), 32'd5);
      @(posedge clk); #1;
    end
    chk("rrGrant0", 32'(order[0]), 32'd0);
    chk("rrGrant1", 32'(order[1]), 32'd1);
    chk("rrGrant2", 32'(order[2]), 32'd0);

    // Reset in the middle of a write abandons it
    drive(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    waitReady(g);
    chk("abortGrant", 32'(g), 32'd0);
    @(posedge clk); #1;
    junk(0);
    @(posedge clk); #1;
    nReset = 1'b0;
    @(negedge clk);
    chk("abortAccWE", 32'(WE), 32'd0);
    @(posedge clk); #1;
    chk("abortCtl", 32'({CS, WE, OE, LBS, HBS}), 32'h1F);
    chk("abortBus", 32'(data), 32'hFFFF);
    nReset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    doReq(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 5, "rdAfterRst");
    chk("rdAfterRstVal", req0_rdata, 32'h00AB_CDEF);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
